add_iter: RTL

Parametrised multi-cycle adder/subtractor and the sequential successor to the single-bit full adder cell. It adds or subtracts two WIDTH-bit operands CHUNK bits per cycle, LSB chunk first, with a registered carry between chunks. Callers use a start/busy/done handshake. It sits in the processor's arithmetic support path where a narrow, area-cheap adder is preferred over a full-width combinational one.

---
 rtl/add_iter_if.sv | 18 +
 rtl/add_iter.sv | 93 +++++++++
 2 files changed

// File: rtl/add_iter_if.sv
// Start/busy/done handshake and operand/result bus for the iterative adder.
interface add_iter_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, cin, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, cin, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/add_iter.sv
// Multi-cycle adder/subtractor: CHUNK bits per beat, LSB chunk first, registered
// inter-chunk carry. Result, carry-out and signed overflow are registered on the last beat.
module add_iter #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic rstn,
  add_iter_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} stateT;

  stateT            state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] nextWork;
  logic [WIDTH-1:0] sumR;
  logic [CW-1:0]    beatCnt;
  logic [CHUNK:0]   chunkSum;
  logic             carry;
  logic             msbCarryIn;
  logic             lastBeat;
  logic             busyR;
  logic             doneR;
  logic             coutR;
  logic             ovfR;

  always_comb begin
    chunkSum = {1'b0, opA[CHUNK-1:0]} + {1'b0, opB[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    nextWork = work >> CHUNK;
    nextWork[WIDTH-1 -: CHUNK] = chunkSum[CHUNK-1:0];
    // On the last beat the chunk's top bit is the word MSB; recover its carry-in from the sum bit.
    msbCarryIn = opA[CHUNK-1] ^ opB[CHUNK-1] ^ chunkSum[CHUNK-1];
    lastBeat   = (beatCnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      opA     <= '0;
      opB     <= '0;
      work    <= '0;
      sumR    <= '0;
      beatCnt <= '0;
      carry   <= 1'b0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      coutR   <= 1'b0;
      ovfR    <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opA     <= bus.a;
            opB     <= bus.b ^ {WIDTH{bus.sub}};
            carry   <= bus.sub | bus.cin;
            beatCnt <= '0;
            work    <= '0;
            busyR   <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          opA     <= opA >> CHUNK;
          opB     <= opB >> CHUNK;
          carry   <= chunkSum[CHUNK];
          work    <= nextWork;
          beatCnt <= beatCnt + CW'(1);
          if (lastBeat) begin
            sumR  <= nextWork;
            coutR <= chunkSum[CHUNK];
            ovfR  <= msbCarryIn ^ chunkSum[CHUNK];
            doneR <= 1'b1;
            busyR <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busyR;
  assign bus.done = doneR;
  assign bus.sum  = sumR;
  assign bus.cout = coutR;
  assign bus.ovf  = ovfR;
endmodule
